glitcbus_slave: RTL and testbench

GLITC-side endpoint of the GLITCBUS. Receives serialized byte-wide transactions driven by the TISC GLITCBUS master over GSEL_B/GRDWR_B/GAD and converts each one into a single 32-bit access on a local register strobe bus inside the GLITC. Writes are assembled and committed. Reads are issued locally and the result is serialized back onto GAD after a fixed turnaround.

---
 rtl/glitcbus_pkg.sv | 21 ++
 rtl/glitcbus_byte_shifter.sv | 23 ++
 rtl/glitcbus_slave.sv | 182 ++++++++++++++++++
 tb/tb_glitcbus_slave.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/glitcbus_pkg.sv
// rtl/glitcbus_pkg.sv - shared GLITCBUS constants, widths and state encoding
package glitcbus_pkg;

  localparam int ADDR_BYTES = 3;
  localparam int DATA_BYTES = 4;
  localparam int ADR_W      = 18;

  localparam logic GB_READ  = 1'b1;
  localparam logic GB_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_WCOMMIT,
    ST_RWAIT,
    ST_RDATA,
    ST_DONE
  } gb_state_t;

endpackage

// File: rtl/glitcbus_byte_shifter.sv
// rtl/glitcbus_byte_shifter.sv - 32-bit MSB-first load / byte shift register
module glitcbus_byte_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        shift,
  input  logic [31:0] din,
  input  logic [7:0]  byte_in,
  output logic [31:0] q
);

  // A shift both captures byte_in at the bottom and exposes the next byte at the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[23:0], byte_in};
    end
  end

endmodule

// File: rtl/glitcbus_slave.sv
// rtl/glitcbus_slave.sv - GLITC-side GLITCBUS endpoint bridging to the local register strobe bus
module glitcbus_slave #(
  parameter int          READ_WAIT      = 4,
  parameter logic [31:0] RD_TIMEOUT_VAL = 32'hFFFFFFFF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        gsel_b_i,
  input  logic        grdwr_b_i,
  input  logic [7:0]  gad_i,
  output logic [7:0]  gad_o,
  output logic        gad_oe_o,
  output logic [17:0] reg_adr_o,
  output logic [31:0] reg_dat_o,
  output logic        reg_we_o,
  output logic        reg_stb_o,
  input  logic [31:0] reg_dat_i,
  input  logic        reg_ack_i,
  output logic        busy_o,
  output logic        rd_timeout_o
);
  import glitcbus_pkg::*;

  localparam logic [3:0] ADDR_LAST = 4'(ADDR_BYTES - 2);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BYTES - 1);
  localparam logic [3:0] RW_PEN    = 4'(READ_WAIT - 2);
  localparam logic [3:0] RW_LAST   = 4'(READ_WAIT - 1);

  gb_state_t         state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [ADR_W-1:0]  adr, adr_nxt;
  logic              rdwr, rdwr_nxt;
  logic              stb, stb_nxt, we, we_nxt, oe, oe_nxt, busy, tmo, tmo_nxt;
  logic              sh_load, sh_shift;
  logic [31:0]       sh_din, sh_q;
  logic [7:0]        sh_byte;

  glitcbus_byte_shifter u_shifter (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .load    (sh_load),
    .shift   (sh_shift),
    .din     (sh_din),
    .byte_in (sh_byte),
    .q       (sh_q)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      adr   <= '0;
      rdwr  <= GB_WRITE;
      stb   <= 1'b0;
      we    <= 1'b0;
      oe    <= 1'b1;
      busy  <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      adr   <= adr_nxt;
      rdwr  <= rdwr_nxt;
      stb   <= stb_nxt;
      we    <= we_nxt;
      oe    <= oe_nxt;
      busy  <= (state_nxt != ST_IDLE);
      tmo   <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 4'd1;
    adr_nxt   = adr;
    rdwr_nxt  = rdwr;
    stb_nxt   = stb;
    we_nxt    = we;
    oe_nxt    = 1'b1;
    tmo_nxt   = 1'b0;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_din    = reg_dat_i;
    sh_byte   = gad_i;

    // Deselect mid-transfer abandons everything except an in-flight write commit.
    if (gsel_b_i && (state == ST_ADDR || state == ST_WDATA ||
                     state == ST_RWAIT || state == ST_RDATA)) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      stb_nxt   = 1'b0;
      we_nxt    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_nxt = '0;
          if (!gsel_b_i) begin
            state_nxt = ST_ADDR;
            adr_nxt   = {gad_i[1:0], 16'h0000};
            rdwr_nxt  = grdwr_b_i;
          end
        end
        ST_ADDR: begin
          if (cnt == 4'd0) adr_nxt[15:8] = gad_i;
          else             adr_nxt[7:0]  = gad_i;
          if (cnt == ADDR_LAST) begin
            cnt_nxt = '0;
            if (rdwr == GB_WRITE) begin
              state_nxt = ST_WDATA;
            end else begin
              state_nxt = ST_RWAIT;
              stb_nxt   = 1'b1;
              we_nxt    = 1'b0;
            end
          end
        end
        ST_WDATA: begin
          sh_shift = 1'b1;
          if (cnt == DATA_LAST) begin
            state_nxt = ST_WCOMMIT;
            cnt_nxt   = '0;
            stb_nxt   = 1'b1;
            we_nxt    = 1'b1;
          end
        end
        ST_WCOMMIT: begin
          cnt_nxt = '0;
          if (reg_ack_i) begin
            state_nxt = ST_DONE;
            stb_nxt   = 1'b0;
            we_nxt    = 1'b0;
          end
        end
        ST_RWAIT: begin
          // Timeout is decided one cycle early so the pulse lands on the last wait cycle.
          if (stb && reg_ack_i) begin
            sh_load = 1'b1;
            stb_nxt = 1'b0;
          end else if (stb && cnt == RW_PEN) begin
            sh_load = 1'b1;
            sh_din  = RD_TIMEOUT_VAL;
            stb_nxt = 1'b0;
            tmo_nxt = 1'b1;
          end
          if (cnt == RW_LAST) begin
            state_nxt = ST_RDATA;
            cnt_nxt   = '0;
            oe_nxt    = 1'b0;
          end
        end
        ST_RDATA: begin
          sh_shift = 1'b1;
          sh_byte  = 8'h00;
          oe_nxt   = 1'b0;
          if (cnt == DATA_LAST) begin
            state_nxt = ST_DONE;
            cnt_nxt   = '0;
            oe_nxt    = 1'b1;
          end
        end
        ST_DONE: begin
          cnt_nxt = '0;
          if (gsel_b_i) state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign gad_o        = sh_q[31:24];
  assign gad_oe_o     = oe;
  assign reg_adr_o    = adr;
  assign reg_dat_o    = sh_q;
  assign reg_we_o     = we;
  assign reg_stb_o    = stb;
  assign busy_o       = busy;
  assign rd_timeout_o = tmo;

endmodule

// File: tb/tb_glitcbus_slave.sv
// tb/tb_glitcbus_slave.sv - table-driven bench for glitcbus_slave with READ_WAIT=4
module tb_glitcbus_slave;

  logic        clk, rst_n, gsel_b, grdwr_b, reg_ack, reg_we, reg_stb, busy, rd_timeout, gad_oe;
  logic [7:0]  gad_in, gad_out;
  logic [17:0] reg_adr;
  logic [31:0] reg_dat_out, reg_dat_in;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        gsel_b;
    logic        rdwr_b;
    logic [7:0]  gad;
    logic        ack;
    logic [31:0] dat;
    logic        e_stb;
    logic        e_we;
    logic        e_oe;
    logic [7:0]  e_gad;
    logic        e_busy;
    logic        e_tmo;
    logic        chk_adr;
    logic [17:0] e_adr;
    logic        chk_dat;
    logic [31:0] e_dat;
  } vec_t;

  vec_t tbl [36];

  glitcbus_slave #(.READ_WAIT(4), .RD_TIMEOUT_VAL(32'hFFFFFFFF)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .gsel_b_i     (gsel_b),
    .grdwr_b_i    (grdwr_b),
    .gad_i        (gad_in),
    .gad_o        (gad_out),
    .gad_oe_o     (gad_oe),
    .reg_adr_o    (reg_adr),
    .reg_dat_o    (reg_dat_out),
    .reg_we_o     (reg_we),
    .reg_stb_o    (reg_stb),
    .reg_dat_i    (reg_dat_in),
    .reg_ack_i    (reg_ack),
    .busy_o       (busy),
    .rd_timeout_o (rd_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic gs, logic rw, logic [7:0] gd, logic ak, logic [31:0] dt,
                              logic stb, logic we, logic oe, logic [7:0] eg, logic bsy, logic tmo);
    vec_t v;
    v.gsel_b = gs;  v.rdwr_b = rw;  v.gad = gd;  v.ack = ak;  v.dat = dt;
    v.e_stb = stb;  v.e_we = we;  v.e_oe = oe;  v.e_gad = eg;  v.e_busy = bsy;  v.e_tmo = tmo;
    v.chk_adr = 1'b0;  v.e_adr = '0;  v.chk_dat = 1'b0;  v.e_dat = '0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic gs, input logic rw, input logic [7:0] gd,
                       input logic ak, input logic [31:0] dt);
    gsel_b = gs;  grdwr_b = rw;  gad_in = gd;  reg_ack = ak;  reg_dat_in = dt;
  endtask

  task automatic apply_row(input int i);
    vec_t v;
    v = tbl[i];
    @(negedge clk);
    chk($sformatf("row%0d stb", i), 32'(reg_stb), 32'(v.e_stb));
    if (v.e_stb) chk($sformatf("row%0d we", i), 32'(reg_we), 32'(v.e_we));
    chk($sformatf("row%0d oe", i), 32'(gad_oe), 32'(v.e_oe));
    if (!v.e_oe) chk($sformatf("row%0d gad", i), 32'(gad_out), 32'(v.e_gad));
    chk($sformatf("row%0d busy", i), 32'(busy), 32'(v.e_busy));
    chk($sformatf("row%0d tmo", i), 32'(rd_timeout), 32'(v.e_tmo));
    if (v.chk_adr) chk($sformatf("row%0d adr", i), 32'(reg_adr), 32'(v.e_adr));
    if (v.chk_dat) chk($sformatf("row%0d dat", i), reg_dat_out, v.e_dat);
    drive(v.gsel_b, v.rdwr_b, v.gad, v.ack, v.dat);
  endtask

  task automatic apply_rows(input int first, input int last);
    for (int i = first; i <= last; i++) apply_row(i);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " gad"},  32'(gad_out), 32'h0);
    chk({tag, " oe"},   32'(gad_oe), 32'h1);
    chk({tag, " adr"},  32'(reg_adr), 32'h0);
    chk({tag, " dat"},  reg_dat_out, 32'h0);
    chk({tag, " we"},   32'(reg_we), 32'h0);
    chk({tag, " stb"},  32'(reg_stb), 32'h0);
    chk({tag, " busy"}, 32'(busy), 32'h0);
    chk({tag, " tmo"},  32'(rd_timeout), 32'h0);
  endtask

  initial begin
    int extra;

    // write: 02 34 56 / DE AD BE EF, ack on first strobe cycle
    tbl[0]  = mk(0, 0, 8'h02, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[1]  = mk(0, 0, 8'h34, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[2]  = mk(0, 0, 8'h56, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[3]  = mk(0, 0, 8'hDE, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[4]  = mk(0, 0, 8'hAD, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[5]  = mk(0, 0, 8'hBE, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[6]  = mk(0, 0, 8'hEF, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[7]  = mk(0, 0, 8'h00, 1, 0, 1, 1, 1, 0, 1, 0);
    tbl[7].chk_adr = 1'b1;  tbl[7].e_adr = 18'h23456;
    tbl[7].chk_dat = 1'b1;  tbl[7].e_dat = 32'hDEADBEEF;
    tbl[8]  = mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[9]  = mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0);
    // read: 00 00 10, ack 12345678 on cycle 4
    tbl[10] = mk(0, 1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[11] = mk(0, 1, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[12] = mk(0, 1, 8'h10, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[13] = mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 1, 0);
    tbl[13].chk_adr = 1'b1;  tbl[13].e_adr = 18'h00010;
    tbl[14] = mk(0, 1, 8'h00, 1, 32'h12345678, 1, 0, 1, 0, 1, 0);
    tbl[15] = mk(0, 1, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[16] = mk(0, 1, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[17] = mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h12, 1, 0);
    tbl[18] = mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h34, 1, 0);
    tbl[19] = mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h56, 1, 0);
    tbl[20] = mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h78, 1, 0);
    tbl[21] = mk(1, 1, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[22] = mk(1, 1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0);
    // read with no ack: A0[7:2] must be ignored, data times out to FF
    tbl[23] = mk(0, 1, 8'hFF, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[24] = mk(0, 1, 8'hFF, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[25] = mk(0, 1, 8'h01, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[26] = mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 1, 0);
    tbl[26].chk_adr = 1'b1;  tbl[26].e_adr = 18'h3FF01;
    tbl[27] = mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 1, 0);
    tbl[28] = mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 1, 0);
    tbl[29] = mk(0, 1, 8'h00, 0, 0, 0, 0, 1, 0, 1, 1);
    tbl[30] = mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'hFF, 1, 0);
    tbl[31] = mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'hFF, 1, 0);
    tbl[32] = mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'hFF, 1, 0);
    tbl[33] = mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 8'hFF, 1, 0);
    tbl[34] = mk(1, 1, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[35] = mk(1, 1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0);

    rst_n = 1'b0;
    drive(1, 0, 8'h00, 0, 0);
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    apply_rows(0, 9);
    apply_rows(10, 22);
    apply_rows(23, 35);

    // abort after data byte 2 of a write
    apply_rows(0, 5);
    @(negedge clk);
    chk("abort c6 busy", 32'(busy), 32'h1);
    drive(1, 0, 8'h00, 1, 0);
    @(negedge clk);
    chk("abort c7 busy", 32'(busy), 32'h0);
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      if (reg_stb) extra++;
      @(negedge clk);
    end
    chk("abort stb count", 32'(extra), 32'h0);
    drive(1, 0, 8'h00, 0, 0);

    // select held low after a completed write
    apply_rows(0, 7);
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (reg_stb) extra++;
      drive(0, 0, 8'h02, 0, 0);
    end
    chk("held extra stb", 32'(extra), 32'h0);
    @(negedge clk);
    chk("held busy", 32'(busy), 32'h1);
    drive(1, 0, 8'h00, 0, 0);
    apply_rows(0, 9);

    // asynchronous reset in the middle of RDATA
    apply_rows(10, 18);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    drive(1, 0, 8'h00, 0, 0);
    rst_n = 1'b1;
    apply_rows(0, 9);
    apply_rows(10, 22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
